// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over WIDTH cycles,
// then sign fix-up and a one-cycle done pulse.
module mdu_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       f3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]         op_q;
    logic               neg_a_q, neg_b_q, div0_q;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   rem_q, quo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;

    // Operand decode at accept time
    logic             signed_a, signed_b, neg_a, neg_b;
    logic [WIDTH-1:0] abs_a, abs_b;

    always_comb begin
        signed_a = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
        signed_b = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
        neg_a    = signed_a && a[WIDTH-1];
        neg_b    = signed_b && b[WIDTH-1];
        abs_a    = neg_a ? -a : a;
        abs_b    = neg_b ? -b : b;
    end

    // Per-iteration datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mag_b_q};
        // remainder stays below the divisor, so the low WIDTH bits hold the difference
        div_diff  = div_shift[WIDTH-1:0] - mag_b_q;
    end

    // Sign correction and output select
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_fix;

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
        rem_fix  = neg_a_q ? -rem_q : rem_q;
        res_fix  = '0;
        case (op_q)
            3'b000:                 res_fix = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: res_fix = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         res_fix = div0_q ? '1 : quo_fix;
            default:                res_fix = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= f3;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        div0_q  <= (b == '0);
                        mag_a_q <= abs_a;
                        mag_b_q <= abs_b;
                        prod_q  <= {{WIDTH{1'b0}}, abs_b};
                        rem_q   <= '0;
                        quo_q   <= abs_a;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (op_q[2]) begin
                        rem_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], div_ge};
                    end else begin
                        prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    result_q <= res_fix;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed WIDTH=32 cases plus a randomized
// WIDTH=8 sweep against an arithmetic reference model.
module tb_mdu_seq;

    logic        clk;
    logic        reset;
    logic        start32, start8;
    logic [2:0]  f3_32, f3_8;
    logic [31:0] a32, b32, res32;
    logic [7:0]  a8, b8, res8;
    logic        busy32, done32, busy8, done8;

    int total = 0;
    int bad   = 0;

    mdu_seq #(.WIDTH(32)) u_mdu32 (
        .clk(clk), .reset(reset), .start(start32), .f3(f3_32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32)
    );

    mdu_seq #(.WIDTH(8)) u_mdu8 (
        .clk(clk), .reset(reset), .start(start8), .f3(f3_8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RV32M semantics at width w using 64-bit arithmetic
    function automatic logic [31:0] ref_op(input int w, input logic [2:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, sa, sb, p;
        longint      sai, sbi;
        logic        ovf;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = a[w-1] ? (ua | ~mask) : ua;
        sb   = b[w-1] ? (ub | ~mask) : ub;
        sai  = longint'(sa);
        sbi  = longint'(sb);
        ovf  = (ua == (64'd1 << (w - 1))) && (ub == mask);
        case (f)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >> w;
            3'd2: p = (sa * ub) >> w;
            3'd3: p = (ua * ub) >> w;
            3'd4: p = (ub == 0) ? mask : ovf ? ua : 64'(sai / sbi);
            3'd5: p = (ub == 0) ? mask : ua / ub;
            3'd6: p = (ub == 0) ? ua : ovf ? 64'd0 : 64'(sai % sbi);
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(p & mask);
    endfunction

    // One 32-bit op; inject > 0 pulses start with junk operands at that cycle
    task automatic run32(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int inject);
        logic [31:0] exp;
        int lat, bcnt;
        exp = ref_op(32, f, a, b);
        @(negedge clk);
        start32 = 1'b1; f3_32 = f; a32 = a; b32 = b;
        @(posedge clk);
        #1;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; f3_32 = 3'($urandom);
        lat = 0; bcnt = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy32) bcnt++;
            if (done32) break;
            if (inject != 0 && lat == inject) begin
                start32 = 1'b1; a32 = $urandom; b32 = $urandom; f3_32 = 3'($urandom);
            end else begin
                start32 = 1'b0;
            end
        end
        start32 = 1'b0;
        check({tag, ":lat"}, lat, 34);
        check({tag, ":busy"}, bcnt, 34);
        check({tag, ":res"}, res32, exp);
        @(negedge clk);
        check({tag, ":pulse"}, done32, 0);
        check({tag, ":idle"}, busy32, 0);
        check({tag, ":hold"}, res32, exp);
    endtask

    task automatic run8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [31:0] exp;
        int lat;
        exp = ref_op(8, f, {24'd0, a}, {24'd0, b});
        @(negedge clk);
        start8 = 1'b1; f3_8 = f; a8 = a; b8 = b;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done8) break;
        end
        check($sformatf("w8 f3=%0d a=%0h b=%0h :lat", f, a, b), lat, 10);
        check($sformatf("w8 f3=%0d a=%0h b=%0h :res", f, a, b), res8, {24'd0, exp[7:0]});
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic seen;
        reset = 1'b1;
        start32 = 1'b0; f3_32 = '0; a32 = '0; b32 = '0;
        start8 = 1'b0;  f3_8 = '0;  a8 = '0;  b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst:busy32", busy32, 0);
        check("rst:done32", done32, 0);
        check("rst:res32", res32, 0);
        check("rst:busy8", busy8, 0);
        check("rst:res8", res8, 0);

        // reset has priority over a simultaneous start
        start32 = 1'b1; f3_32 = 3'd0; a32 = 32'd3; b32 = 32'd3;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        reset = 1'b0;
        check("rst_vs_start:busy", busy32, 0);

        run32("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 0);
        run32("mulh",   3'd1, 32'h80000000, 32'h80000000, 0);
        run32("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run32("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run32("div",    3'd4, 32'hFFFFFFF9, 32'd2,        0);
        run32("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        0);
        run32("divu",   3'd5, 32'd100,      32'd7,        0);
        run32("remu",   3'd7, 32'd100,      32'd7,        0);
        run32("divu0",  3'd5, 32'd5,        32'd0,        0);
        run32("remu0",  3'd7, 32'd5,        32'd0,        0);
        run32("div0",   3'd4, 32'hFFFFFFF9, 32'd0,        0);
        run32("rem0",   3'd6, 32'hFFFFFFF9, 32'd0,        0);
        run32("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
        run32("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
        run32("ignore", 3'd0, 32'd12345,    32'd678,      5);

        // reset mid-operation
        @(negedge clk);
        start32 = 1'b1; f3_32 = 3'd0; a32 = 32'd9; b32 = 32'd9;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort:busy", busy32, 0);
        check("abort:done", done32, 0);
        check("abort:res", res32, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        check("abort:nodone", seen, 0);
        run32("after_abort", 3'd5, 32'd1000, 32'd33, 0);

        for (int i = 0; i < 150; i++) begin
            run8(3'(i % 8), pick8(), pick8());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide unit for the RV32M extension, executing one operation at a time.
- Sits beside the single-cycle ALU in the execute stage. The control unit raises `start` with funct3 when it decodes an R-type instruction with funct7 = 0000001.
- The unit stalls the pipeline via `busy` and returns the result with a one-cycle `done` pulse.
- Operand width is parametrised so that narrow cores and the same bench can reuse the block.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy = 0.
- f3  in  3  funct3 operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 operand; sampled with start.
- b  in  WIDTH  rs2 operand; sampled with start.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  WIDTH  operation result; held until the next done.

Behaviour:
- Reset (synchronous, active-high): state = IDLE, busy = 0, done = 0, result = 0, counter = 0. Reset wins over start in the same cycle.
- Reset mid-operation aborts the operation immediately. There is no done pulse, and result reads 0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE -> RUN on start = 1 (edge at cycle T):
  - latch f3, a, b;
  - compute operand signs: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM;
  - store absolute values; counter = 0.
- RUN: one bit per cycle for exactly WIDTH cycles (T+1 .. T+WIDTH). The state moves to FIX when counter = WIDTH-1.
  - Multiply: shift-add over a 2*WIDTH product register.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and remainder.
- FIX (cycle T+WIDTH+1): apply sign correction, select the output, and load the result register.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits.
- DONE (cycle T+WIDTH+2): done = 1 for this cycle only; next state IDLE.
- Fixed latency: start accepted at edge T, done high in cycle T+WIDTH+2 for every opcode, including the special cases below.
- Back-to-back: the earliest next accept is the IDLE cycle after DONE, so the issue interval is WIDTH+3 cycles.
- start while busy = 1 is ignored. Operands are not re-sampled and no error is raised.
- Divide by zero (b = 0), run at full latency:
  - DIV and DIVU: result = all ones;
  - REM and REMU: result = a.
- Signed overflow (DIV/REM with a = 100..0 and b = all ones), run at full latency:
  - DIV: result = a;
  - REM: result = 0.
- All arithmetic is modulo 2^WIDTH. Absolute value of the most negative number is handled as an unsigned magnitude.
- Inputs a, b and f3 may change while busy without affecting the operation in flight.

Test Plan:
- WIDTH=32, MUL a=7, b=0xFFFFFFFD -> done exactly 34 cycles after the accept edge, result=0xFFFFFFEB; busy high for 34 cycles.
- MULH with a=b=0x80000000 -> 0x40000000.
- MULHU with a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU with a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF.
- DIVU a=100, b=7 -> 14; REMU on the same operands -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM on the same operands -> 0. Each completes at the normal latency of 34.
- Robustness:
  - Pulse start again with new operands at cycle T+5 -> ignored; the first result is unchanged.
  - Assert reset at T+10 -> busy=0, done never pulses, result=0; a fresh start afterwards completes correctly.
- WIDTH=8 random sweep against a reference model, all eight f3 codes -> results match and latency = 10 cycles.
